uart_rx_cfg: RTL
================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised oversampling UART receiver; successor to the fixed 8-bit receiver.
//  Serial din -> parallel word + error flags, valid/ready output handshake.
//  Adds runtime baud divisor, parity mode (none/even/odd), 1 or 2 stop bits.
//  Adds false-start rejection and overrun-safe holding. Sits between pad sync and host/FIFO.
// PARAMETERS
//  DATA_W  8   data bits per frame, legal 5..9, LSB first on the line
//  OVS     16  oversample ticks per bit, even, >=8
//  DIV_W   16  width of baud divisor input
// PORTS
//  clk       in   1       single clock; all logic posedge clk
//  rst_n     in   1       synchronous, active-low reset
//  din       in   1       serial line, async; idle high
//  baud_div  in   DIV_W   one oversample tick every baud_div+1 clk
//  par_mode  in   2       00 none, 01 even, 10 odd, 11 reserved (= none)
//  stop2     in   1       1 = two stop bits checked
//  rx_data   out  DATA_W  received word
//  rx_err    out  3       {parity, overrun, frame}, qualified by rx_valid
//  rx_valid  out  1       word held; stays high until rx_ready
//  rx_ready  in   1       consumer accepts when rx_valid && rx_ready
//  rx_busy   out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): FSM->IDLE; tick/bit counters 0; sync flops 1; rx_data 0; rx_err 0; rx_valid 0; rx_busy 0.
//  Reset mid-frame aborts the frame, with no output.
//  din passes a 2-flop synchroniser, rxs; 2-cycle input latency.
//  Tick gen: counter 0..baud_div, tick when it equals baud_div, then wraps to 0; free-running.
//  Bit period = OVS*(baud_div+1) clk. Each bit's sample point is at tick OVS/2 of that bit.
//  baud_div, par_mode, stop2 are latched at start detect; changes mid-frame have no effect.
//  FSM states IDLE, START, DATA, PARITY, STOP:
//   IDLE: on rxs 1->0 go to START; tick count cleared.
//   START: at tick OVS/2-1 sample. If 1, false start -> IDLE, no output. If 0, go to DATA.
//   DATA: sample every OVS ticks and shift in LSB first. After DATA_W bits -> PARITY if par_mode in {01,10}, else STOP.
//   PARITY: sample. Parity error = (XOR of data ^ sample) != (mode==odd).
//   STOP: sample 1 or 2 stop bits, OVS apart. Any 0 sets frame.
//   After the last stop sample, the FSM goes to IDLE immediately; it does not wait for the end of the bit.
//  Completion: the cycle after the last stop sample, word and flags are written and rx_valid=1.
//  Handshake: rx_valid && rx_ready clears rx_valid next cycle.
//   A completion in the same cycle as an accept loads the new word, and rx_valid stays 1.
//  Overrun: completion while rx_valid && !rx_ready -> new frame dropped.
//   Held word unchanged; its rx_err[1] set to 1. It clears with the word.
//  Frame error still delivers the word, with rx_err[0]=1.
//  Break (line held low) yields one frame-error word. A new start needs rxs to return high first.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: each sample = 2-of-3 majority of rxs at ticks OVS/2-1, OVS/2, OVS/2+1.
//  UART_RX_MAJORITY_EN undefined: single sample of rxs at tick OVS/2.
//  Frame timing is identical in both builds.
// STRUCTURE
//  Package uart_pkg: state enum (IDLE..STOP), par_mode constants (PAR_NONE/EVEN/ODD), rx_err bit indices.
//  Sub-module uart_baud_tick (DIV_W): divisor counter, outputs 1-cycle tick; restart input cleared by start detect.
//  Rest inline: synchroniser, FSM, shifter, parity XOR, holding register.
// TESTING (OVS=16, baud_div=0 -> 16 clk/bit unless noted)
//  1. 0xA5, no parity, 1 stop, rx_ready=1 -> rx_data=0xA5, rx_err=000, one valid pulse about 9.5 bit times after start edge.
//  2. Even parity, 0x03 with parity bit 1 -> rx_data=0x03, rx_err=100; same with bit 0 -> 000. Odd mode inverts.
//  3. stop2=1, 0x5A, second stop bit 0 -> rx_err=001; rx_busy=0 afterwards.
//  4. rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11, rx_err=010. Raise ready -> rx_valid drops; 0x22 never seen.
//  5. din low for 4 clk in idle -> no rx_valid; FSM back in IDLE within 8 ticks.
//     baud_div=3 -> bit = 64 clk; 0x3C received intact.
//  6. 1-clk high glitch at the bit-3 centre of 0x00: with UART_RX_MAJORITY_EN -> 0x00; without -> 0x08.
//     rst_n pulse mid-frame -> all outputs 0, no word.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the configurable UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int ERR_PARITY  = 2;
    localparam int ERR_OVERRUN = 1;
    localparam int ERR_FRAME   = 0;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module      : uart_baud_tick
// Description : Free-running divisor counter; one-cycle tick every div+1 clk.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        tick = (cnt_q == div);
        if (restart || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_cfg.sv
// ============================================================================
// Module      : uart_rx_cfg
// Description : Oversampling UART receiver with runtime divisor, parity and
//               stop-bit configuration, valid/ready holding register.
//               Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OVS    = 16,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        par_mode,
    input  logic              stop2,
    output logic [DATA_W-1:0] rx_data,
    output logic [2:0]        rx_err,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_busy
);

    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DATA_W);
    localparam logic [TW-1:0] START_PT = TW'(OVS / 2);
    localparam logic [TW-1:0] BIT_PT   = TW'(OVS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

`ifdef UART_RX_MAJORITY_EN
    localparam int HIST_W = 2;
`else
    localparam int HIST_W = 1;
`endif

    rx_state_e         state_q, state_d;
    logic              s1_q, s1_d, rxs_q, rxs_d, rxs_prev_q, rxs_prev_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [HIST_W-1:0] hist_q, hist_d;
    logic              par_err_q, par_err_d, frame_q, frame_d, stop_cnt_q, stop_cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        par_q, par_d;
    logic              stop2_q, stop2_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [2:0]        rx_err_q, rx_err_d;
    logic              rx_valid_q, rx_valid_d;

    logic tick, start_det, decide, sample, complete;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (start_det),
        .div     (div_q),
        .tick    (tick)
    );

    // The decision lands one tick after the centre so both sampling modes
    // share identical frame timing.
`ifdef UART_RX_MAJORITY_EN
    assign sample = maj3(hist_q[1], hist_q[0], rxs_q);
`else
    assign sample = hist_q[0];
`endif

    assign decide = tick && (state_q != IDLE) &&
                    (tcnt_q == ((state_q == START) ? START_PT : BIT_PT));

    always_comb begin
        s1_d       = din;
        rxs_d      = s1_q;
        rxs_prev_d = rxs_q;
        state_d    = state_q;
        tcnt_d     = tick ? (decide ? '0 : tcnt_q + TW'(1)) : tcnt_q;
        hist_d     = tick ? HIST_W'({hist_q, rxs_q}) : hist_q;
        bcnt_d     = bcnt_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        frame_d    = frame_q;
        stop_cnt_d = stop_cnt_q;
        div_d      = div_q;
        par_d      = par_q;
        stop2_d    = stop2_q;
        start_det  = 1'b0;
        complete   = 1'b0;

        case (state_q)
            IDLE: begin
                tcnt_d = '0;
                if (rxs_prev_q && !rxs_q) begin
                    start_det  = 1'b1;
                    state_d    = START;
                    bcnt_d     = '0;
                    par_err_d  = 1'b0;
                    frame_d    = 1'b0;
                    stop_cnt_d = 1'b0;
                    div_d      = baud_div;
                    par_d      = par_mode;
                    stop2_d    = stop2;
                end
            end
            START: begin
                if (decide) state_d = sample ? IDLE : DATA;
            end
            DATA: begin
                if (decide) begin
                    shift_d = {sample, shift_q[DATA_W-1:1]};
                    if (bcnt_q == LAST_BIT) begin
                        state_d = (par_q == PAR_EVEN || par_q == PAR_ODD) ? PARITY : STOP;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (decide) begin
                    par_err_d = ((^shift_q) ^ sample) != (par_q == PAR_ODD);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    frame_d = frame_q | ~sample;
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register: a full, unaccepted slot drops the new frame and
    // flags overrun against the word already held.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_err_d   = rx_err_q;
        rx_valid_d = rx_valid_q;
        if (complete) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d             = shift_q;
                rx_err_d              = '0;
                rx_err_d[ERR_PARITY]  = par_err_q;
                rx_err_d[ERR_FRAME]   = frame_d;
                rx_valid_d            = 1'b1;
            end else begin
                rx_err_d[ERR_OVERRUN] = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q       <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            state_q    <= IDLE;
            tcnt_q     <= '0;
            hist_q     <= '1;
            bcnt_q     <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            frame_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            div_q      <= '0;
            par_q      <= PAR_NONE;
            stop2_q    <= 1'b0;
            rx_data_q  <= '0;
            rx_err_q   <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            rxs_q      <= rxs_d;
            rxs_prev_q <= rxs_prev_d;
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            hist_q     <= hist_d;
            bcnt_q     <= bcnt_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            frame_q    <= frame_d;
            stop_cnt_q <= stop_cnt_d;
            div_q      <= div_d;
            par_q      <= par_d;
            stop2_q    <= stop2_d;
            rx_data_q  <= rx_data_d;
            rx_err_q   <= rx_err_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_err   = rx_err_q;
    assign rx_valid = rx_valid_q;
    assign rx_busy  = (state_q != IDLE);

endmodule

`default_nettype wire
